// File: rtl/fir_sample_scheduler.sv
// fir_sample_scheduler
//   Time-multiplexed FIR between the I2S ADC output and the I2S DAC input.
//   Each accepted sample goes into a circular delay line. One shared
//   multiply-accumulate then walks over all taps. The sum is scaled by
//   2^-CoeffFracBits, saturated to DataWidth and presented as one DAC sample.
//
// Ports
//   clk, reset        : single clock, asynchronous active-high reset
//   adcData/Valid     : input sample and its single-cycle qualifier
//   bypass            : sampled with an accepted sample; routes it straight out
//   dacData/Valid     : output sample (held) and its single-cycle qualifier
//   coeffWr*          : coefficient register-file write port
//   busy              : high whenever the FSM is not IDLE
//   overrun/Clear     : sticky drop flag and its clear strobe (set wins)
//   dbgState          : current FSM state, for observation only
//
// Handshakes
//   Samples: there is no backpressure. adcDataValid is consumed in IDLE.
//            In any other state the pulse is dropped and overrun is set.
//   Coefficients: a write completes on a cycle with coeffWrEn && coeffWrReady.
//            coeffWrReady is high only in IDLE. Writes seen while not ready
//            are discarded, not queued.
module fir_sample_scheduler #(
  parameter int DataWidth     = 12,
  parameter int CoeffWidth    = 12,
  parameter int CoeffFracBits = 10,
  parameter int NumTaps       = 8,
  localparam int AddrWidth    = $clog2(NumTaps),
  localparam int AccWidth     = DataWidth + CoeffWidth + $clog2(NumTaps)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DataWidth-1:0] adcData,
  input  logic                        adcDataValid,
  input  logic                        bypass,
  output logic signed [DataWidth-1:0] dacData,
  output logic                        dacDataValid,
  input  logic                        coeffWrEn,
  input  logic [AddrWidth-1:0]        coeffWrAddr,
  input  logic signed [CoeffWidth-1:0] coeffWrData,
  output logic                        coeffWrReady,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        overrunClear,
  output logic [2:0]                  dbgState
);

  localparam int ProdWidth = DataWidth + CoeffWidth;
  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumTaps - 1);
  localparam logic signed [CoeffWidth-1:0] CoeffOne = CoeffWidth'(2 ** CoeffFracBits);
  localparam logic signed [AccWidth-1:0] SatMax = AccWidth'((2 ** (DataWidth - 1)) - 1);
  localparam logic signed [AccWidth-1:0] SatMin = ~SatMax;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DataWidth-1:0]  r_delay [NumTaps];
  logic signed [CoeffWidth-1:0] r_coeff [NumTaps];
  logic signed [DataWidth-1:0]  r_sample;
  logic signed [DataWidth-1:0]  r_dac;
  logic signed [AccWidth-1:0]   r_acc;
  logic [AddrWidth-1:0]         r_wr_ptr;
  logic [AddrWidth-1:0]         r_rd_ptr;
  logic [AddrWidth-1:0]         r_tap;
  logic                         r_overrun;

  logic                         w_idle;
  logic                         w_last_tap;
  logic                         w_addr_ok;
  logic signed [ProdWidth-1:0]  w_prod;
  logic signed [AccWidth-1:0]   w_prod_ext;
  logic signed [AccWidth-1:0]   w_shift;
  logic signed [DataWidth-1:0]  w_sat;

  assign w_idle     = (r_state == S_IDLE);
  assign w_last_tap = (r_tap == LastIdx);
  // The extra leading bit keeps the range check honest when NumTaps is not a power of 2.
  assign w_addr_ok  = ({1'b0, coeffWrAddr} < (AddrWidth + 1)'(NumTaps));

  // Tap k reads x[wrPtr - k]. r_rd_ptr starts at the write pointer and walks backwards.
  assign w_prod     = r_coeff[r_tap] * r_delay[r_rd_ptr];
  assign w_prod_ext = {{(AccWidth - ProdWidth){w_prod[ProdWidth-1]}}, w_prod};
  assign w_shift    = r_acc >>> CoeffFracBits;

  always_comb begin
    w_sat = w_shift[DataWidth-1:0];
    if (w_shift > SatMax) begin
      w_sat = SatMax[DataWidth-1:0];
    end else if (w_shift < SatMin) begin
      w_sat = SatMin[DataWidth-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (adcDataValid) w_next = bypass ? S_DONE : S_LOAD;
      S_LOAD:  w_next = S_MAC;
      S_MAC:   if (w_last_tap) w_next = S_SCALE;
      S_SCALE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumTaps; i++) begin
        r_delay[i] <= '0;
      end
      r_sample <= '0;
      r_dac    <= '0;
      r_acc    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_tap    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (adcDataValid) begin
            if (bypass) begin
              r_dac <= adcData;
            end else begin
              r_sample <= adcData;
            end
          end
        end
        S_LOAD: begin
          r_delay[r_wr_ptr] <= r_sample;
          r_acc             <= '0;
          r_tap             <= '0;
          r_rd_ptr          <= r_wr_ptr;
        end
        S_MAC: begin
          r_acc    <= r_acc + w_prod_ext;
          r_tap    <= r_tap + AddrWidth'(1);
          r_rd_ptr <= (r_rd_ptr == '0) ? LastIdx : r_rd_ptr - AddrWidth'(1);
          if (w_last_tap) begin
            r_wr_ptr <= (r_wr_ptr == LastIdx) ? '0 : r_wr_ptr + AddrWidth'(1);
          end
        end
        S_SCALE: begin
          r_dac <= w_sat;
        end
        default: begin
        end
      endcase
    end
  end

  // The coefficient file is only written in IDLE. A write in the same cycle
  // as an accepted sample therefore lands before that sample's MAC pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumTaps; i++) begin
        r_coeff[i] <= (i == 0) ? CoeffOne : '0;
      end
    end else if (coeffWrEn && w_idle && w_addr_ok) begin
      r_coeff[coeffWrAddr] <= coeffWrData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (adcDataValid && !w_idle) begin
      r_overrun <= 1'b1;
    end else if (overrunClear) begin
      r_overrun <= 1'b0;
    end
  end

  assign dacData      = r_dac;
  assign dacDataValid = (r_state == S_DONE);
  assign coeffWrReady = w_idle;
  assign busy         = !w_idle;
  assign overrun      = r_overrun;
  assign dbgState     = r_state;

endmodule

// File: tb/tb_fir_sample_scheduler.sv
module tb_fir_sample_scheduler;

  localparam int DW = 12;
  localparam int CW = 12;
  localparam int FB = 10;
  localparam int NT = 8;
  localparam int AW = 3;
  localparam int FILT_LAT = NT + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic signed [DW-1:0] adcData = '0;
  logic                 adcDataValid = 1'b0;
  logic                 bypass = 1'b0;
  logic signed [DW-1:0] dacData;
  logic                 dacDataValid;
  logic                 coeffWrEn = 1'b0;
  logic [AW-1:0]        coeffWrAddr = '0;
  logic signed [CW-1:0] coeffWrData = '0;
  logic                 coeffWrReady;
  logic                 busy;
  logic                 overrun;
  logic                 overrunClear = 1'b0;
  logic [2:0]           dbg_state;

  fir_sample_scheduler #(
    .DataWidth(DW), .CoeffWidth(CW), .CoeffFracBits(FB), .NumTaps(NT)
  ) dut (
    .clk(clk), .reset(reset),
    .adcData(adcData), .adcDataValid(adcDataValid), .bypass(bypass),
    .dacData(dacData), .dacDataValid(dacDataValid),
    .coeffWrEn(coeffWrEn), .coeffWrAddr(coeffWrAddr), .coeffWrData(coeffWrData),
    .coeffWrReady(coeffWrReady), .busy(busy),
    .overrun(overrun), .overrunClear(overrunClear),
    .dbgState(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int mc[NT];     // coefficient values as the filter should see them
  int hist[$];    // accepted filtered samples, newest first

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < NT; i++) mc[i] = (i == 0) ? (1 << FB) : 0;
  endtask

  // y = clamp(floor(sum_k c[k]*x[n-k] / 2^FB)); missing history counts as zero
  function automatic int model_filter(input int x);
    longint acc = 0;
    hist.push_front(x);
    if (hist.size() > NT) void'(hist.pop_back());
    for (int k = 0; k < hist.size(); k++) acc += longint'(mc[k]) * longint'(hist[k]);
    acc = acc >>> FB;
    if (acc > 2047) acc = 2047;
    if (acc < -2048) acc = -2048;
    return int'(acc);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_coeff(input int addr, input int val, input bit exp_ready);
    @(negedge clk);
    coeffWrEn = 1'b1;
    coeffWrAddr = AW'(addr);
    coeffWrData = CW'(val);
    chk("coeff_wr_ready", coeffWrReady, exp_ready);
    if (exp_ready) mc[addr] = val;
    @(negedge clk);
    coeffWrEn = 1'b0;
  endtask

  // mode 0: plain; 1: extra adc pulse while busy; 2: coeff write while busy;
  // 3: extra adc pulse together with overrunClear while busy
  task automatic run_sample(input int x, input bit byp, input int mode);
    int n;
    int expv;
    logic [DW-1:0] e;
    expv = byp ? x : model_filter(x);
    exp_q.push_back(DW'(expv));
    @(negedge clk);
    adcData = DW'(x);
    adcDataValid = 1'b1;
    bypass = byp;
    @(negedge clk);
    adcDataValid = 1'b0;
    bypass = ~byp;  // must not influence the sample in flight
    n = 1;
    while (dacDataValid !== 1'b1 && n < 40) begin
      chk("busy_during", busy, 1);
      if (n == 2 && mode != 0) begin
        if (mode == 1 || mode == 3) begin
          adcData = 12'sh3A5;
          adcDataValid = 1'b1;
          overrunClear = (mode == 3);
        end else begin
          coeffWrEn = 1'b1;
          coeffWrAddr = '0;
          coeffWrData = 12'sh155;
          chk("coeff_ready_busy", coeffWrReady, 0);
        end
      end
      @(negedge clk);
      adcDataValid = 1'b0;
      overrunClear = 1'b0;
      coeffWrEn = 1'b0;
      n++;
    end
    chk("latency", n, byp ? 1 : FILT_LAT);
    e = exp_q.pop_front();
    chk("dac_data", dacData, $signed(e));
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    bypass = 1'b0;
    chk("valid_one_cycle", dacDataValid, 0);
    chk("busy_after", busy, 0);
    chk("held_data", dacData, $signed(e));
  endtask

  task automatic count_stray(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dacDataValid === 1'b1) cnt++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int stray;
    model_reset();
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dac", dacData, 0);
    chk("rst_valid", dacDataValid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", coeffWrReady, 1);

    // identity coefficients
    run_sample(100, 1'b0, 0);

    // 0.125 on every tap: impulse 1000 gives eight outputs of 125, then 0
    for (int i = 0; i < NT; i++) write_coeff(i, 128, 1'b1);
    for (int i = 0; i < NT; i++) run_sample(0, 1'b0, 0);
    run_sample(1000, 1'b0, 0);
    for (int i = 0; i < NT; i++) run_sample(0, 1'b0, 0);

    // unity on every tap: saturation at both rails
    for (int i = 0; i < NT; i++) write_coeff(i, 1024, 1'b1);
    for (int i = 0; i < NT; i++) run_sample(2047, 1'b0, 0);
    for (int i = 0; i < NT; i++) run_sample(-2048, 1'b0, 0);

    // dropped sample
    run_sample(321, 1'b0, 1);
    count_stray(16, stray);
    chk("no_extra_output", stray, 0);
    chk("overrun_set", overrun, 1);
    @(negedge clk); overrunClear = 1'b1;
    @(negedge clk); overrunClear = 1'b0;
    chk("overrun_cleared", overrun, 0);
    run_sample(-77, 1'b0, 3);
    chk("overrun_set_wins", overrun, 1);
    @(negedge clk); overrunClear = 1'b1;
    @(negedge clk); overrunClear = 1'b0;
    chk("overrun_cleared2", overrun, 0);

    // coefficient write while busy is ignored
    run_sample(500, 1'b0, 2);
    for (int i = 0; i < NT; i++) run_sample(0, 1'b0, 0);
    run_sample(1000, 1'b0, 0);
    run_sample(0, 1'b0, 0);

    // bypass
    run_sample(-5, 1'b1, 0);

    // reset in the middle of MAC
    @(negedge clk); adcData = 12'sd777; adcDataValid = 1'b1;
    @(negedge clk); adcDataValid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_mid_mac", busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_mac_valid", dacDataValid, 0);
    chk("rst_mac_busy", busy, 0);
    chk("rst_mac_dac", dacData, 0);
    chk("rst_mac_ready", coeffWrReady, 1);
    @(negedge clk); reset = 1'b0;
    model_reset();
    count_stray(16, stray);
    chk("no_output_after_rst", stray, 0);
    run_sample(100, 1'b0, 0);

    // random coefficients and samples, random bypass
    for (int i = 0; i < NT; i++) write_coeff(i, int'($urandom_range(0, 4095)) - 2048, 1'b1);
    for (int i = 0; i < 16; i++) begin
      run_sample(int'($urandom_range(0, 4095)) - 2048, ($urandom_range(0, 3) == 0), 0);
    end
    for (int i = 0; i < NT; i++) write_coeff(i, int'($urandom_range(0, 511)) - 256, 1'b1);
    for (int i = 0; i < 12; i++) begin
      run_sample(int'($urandom_range(0, 4095)) - 2048, 1'b0, 0);
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
